// File: rtl/mouse_tracker.sv
// PS/2 mouse packet decoder: assembles 3-byte packets and tracks a clamped cursor position
// plus button levels, with an inter-byte timeout to resynchronise on lost bytes.
module mouse_tracker #(
  parameter int unsigned H_MAX       = 1023,
  parameter int unsigned V_MAX       = 767,
  parameter int unsigned X_INIT      = 512,
  parameter int unsigned Y_INIT      = 384,
  parameter int unsigned PKT_TIMEOUT = 100_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        left_mouse,
  output logic        right_mouse,
  output logic        middle_mouse,
  output logic        packet_valid,
  output logic        sync_err
);

  localparam logic [13:0] HMax    = 14'(H_MAX);
  localparam logic [13:0] VMax    = 14'(V_MAX);
  localparam logic [19:0] Timeout = 20'(PKT_TIMEOUT);

  typedef enum logic [1:0] {StWaitB0, StWaitB1, StWaitB2, StUpdate} state_e;

  state_e      state_q, state_d;
  logic [19:0] idle_q, idle_d;
  logic [7:0]  b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
  logic [11:0] xpos_q, xpos_d, ypos_q, ypos_d;
  logic [2:0]  btn_q, btn_d;
  logic        pv_q, pv_d, serr_q, serr_d;
  logic        take_b0;
  logic [13:0] x_sum, y_sum;
  logic [11:0] x_new, y_new;
  logic        unused_b0;

  assign unused_b0 = b0_q[3];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StWaitB0;
      idle_q  <= '0;
      b0_q    <= '0;
      b1_q    <= '0;
      b2_q    <= '0;
      xpos_q  <= 12'(X_INIT);
      ypos_q  <= 12'(Y_INIT);
      btn_q   <= '0;
      pv_q    <= 1'b0;
      serr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idle_q  <= idle_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      b2_q    <= b2_d;
      xpos_q  <= xpos_d;
      ypos_q  <= ypos_d;
      btn_q   <= btn_d;
      pv_q    <= pv_d;
      serr_q  <= serr_d;
    end
  end

  // Timeout wins over a coinciding byte, which is then re-evaluated as a byte0.
  always_comb begin
    state_d = state_q;
    idle_d  = '0;
    b0_d    = b0_q;
    b1_d    = b1_q;
    b2_d    = b2_q;
    serr_d  = 1'b0;
    take_b0 = 1'b0;
    unique case (state_q)
      StWaitB0: take_b0 = 1'b1;
      StWaitB1: begin
        if (idle_q == Timeout) begin
          serr_d  = 1'b1;
          state_d = StWaitB0;
          take_b0 = 1'b1;
        end else if (rx_valid) begin
          b1_d    = rx_data;
          state_d = StWaitB2;
        end else begin
          idle_d = idle_q + 20'd1;
        end
      end
      StWaitB2: begin
        if (idle_q == Timeout) begin
          serr_d  = 1'b1;
          state_d = StWaitB0;
          take_b0 = 1'b1;
        end else if (rx_valid) begin
          b2_d    = rx_data;
          state_d = StUpdate;
        end else begin
          idle_d = idle_q + 20'd1;
        end
      end
      StUpdate: begin
        state_d = StWaitB0;
        take_b0 = 1'b1;
      end
      default: state_d = StWaitB0;
    endcase
    if (take_b0 && rx_valid) begin
      if (rx_data[3]) begin
        b0_d    = rx_data;
        state_d = StWaitB1;
      end else begin
        serr_d = 1'b1;
      end
    end
  end

  // 14-bit sums cannot wrap: the extremes are 4095+255 and 0-256.
  always_comb begin
    x_sum = {2'b00, xpos_q} + {{6{b0_q[4]}}, b1_q};
    y_sum = {2'b00, ypos_q} - {{6{b0_q[5]}}, b2_q};
    if (x_sum[13])       x_new = '0;
    else if (x_sum > HMax) x_new = HMax[11:0];
    else                 x_new = x_sum[11:0];
    if (y_sum[13])       y_new = '0;
    else if (y_sum > VMax) y_new = VMax[11:0];
    else                 y_new = y_sum[11:0];

    xpos_d = xpos_q;
    ypos_d = ypos_q;
    btn_d  = btn_q;
    pv_d   = 1'b0;
    if (state_q == StUpdate) begin
      pv_d  = 1'b1;
      btn_d = b0_q[2:0];
      if (!b0_q[6]) xpos_d = x_new;
      if (!b0_q[7]) ypos_d = y_new;
    end
  end

  assign xpos         = xpos_q;
  assign ypos         = ypos_q;
  assign left_mouse   = btn_q[0];
  assign right_mouse  = btn_q[1];
  assign middle_mouse = btn_q[2];
  assign packet_valid = pv_q;
  assign sync_err     = serr_q;

endmodule

// File: tb/tb_mouse_tracker.sv
// Scoreboard bench for mouse_tracker: directed packets push expected cursor/button state,
// a negedge monitor pops and compares on every packet_valid pulse.
module tb_mouse_tracker;

  localparam int unsigned Tmo = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [11:0] xpos, ypos;
  logic        left_mouse, right_mouse, middle_mouse, packet_valid, sync_err;

  mouse_tracker #(.PKT_TIMEOUT(Tmo)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .xpos         (xpos),
    .ypos         (ypos),
    .left_mouse   (left_mouse),
    .right_mouse  (right_mouse),
    .middle_mouse (middle_mouse),
    .packet_valid (packet_valid),
    .sync_err     (sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int b;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_fail = 0;
  int   serr_seen = 0;
  int   pv_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare each packet_valid pulse against the oldest expectation.
  always @(negedge clk) begin
    if (sync_err) serr_seen++;
    if (packet_valid) begin
      pv_seen++;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_packet: got x=%0d y=%0d btn=%0d, required no packet",
                 xpos, ypos, {middle_mouse, right_mouse, left_mouse});
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (int'(xpos) != e.x || int'(ypos) != e.y
            || int'({middle_mouse, right_mouse, left_mouse}) != e.b || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL packet: got x=%0d y=%0d btn=%0d cyc=%0d, required x=%0d y=%0d btn=%0d cyc=%0d",
                   xpos, ypos, {middle_mouse, right_mouse, left_mouse}, cyc,
                   e.x, e.y, e.b, e.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    rx_data  = d;
    rx_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Bytes go out back to back, so the next byte0 lands in the UPDATE cycle.
  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input int ex, input int ey, input int eb);
    exp_t e;
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    e.x = ex; e.y = ey; e.b = eb; e.cyc = cyc + 1;
    exp_q.push_back(e);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_x", int'(xpos), 512);
    check("reset_y", int'(ypos), 384);
    check("reset_btn", int'({middle_mouse, right_mouse, left_mouse}), 0);
    check("reset_pv", int'(packet_valid), 0);
    check("reset_serr", int'(sync_err), 0);
    rst = 1'b1;
    @(negedge clk);

    send_pkt(8'h09, 8'h10, 8'h05, 528, 379, 1);
    send_pkt(8'h28, 8'hFF, 8'hFB, 783, 384, 0);
    send_pkt(8'h08, 8'hED, 8'h00, 1020, 384, 0);
    send_pkt(8'h08, 8'h20, 8'h00, 1023, 384, 0);   // right clamp
    send_pkt(8'h38, 8'h80, 8'h80, 895, 512, 0);
    send_pkt(8'h08, 8'h00, 8'hFF, 895, 257, 0);
    send_pkt(8'h08, 8'h00, 8'hFC, 895, 5, 0);
    send_pkt(8'h08, 8'h00, 8'h0A, 895, 0, 0);      // top clamp
    send_pkt(8'h48, 8'hFF, 8'h00, 895, 0, 0);      // XO holds x
    send_pkt(8'h38, 8'h00, 8'h00, 639, 256, 0);
    send_pkt(8'h38, 8'h00, 8'h00, 383, 512, 0);
    send_pkt(8'h38, 8'h00, 8'h00, 127, 767, 0);    // bottom clamp
    send_pkt(8'h38, 8'h00, 8'h00, 0, 767, 0);      // left clamp
    send_pkt(8'h8B, 8'h05, 8'h05, 5, 767, 3);      // YO holds y
    idle(3);
    check("serr_before_bad_byte", serr_seen, 0);

    send_byte(8'h00);
    idle(3);
    check("serr_bad_byte", serr_seen, 1);
    send_pkt(8'h0C, 8'h00, 8'h00, 5, 767, 4);
    idle(3);

    send_byte(8'h09);
    idle(Tmo - 1);
    check("serr_no_early_timeout", serr_seen, 1);
    idle(4);
    check("serr_timeout", serr_seen, 2);
    send_pkt(8'h0A, 8'h01, 8'h01, 6, 766, 2);
    idle(3);
    check("x_before_reset", int'(xpos), 6);

    send_byte(8'h09);
    send_byte(8'h10);
    rx_valid = 1'b0;
    rst = 1'b0;
    idle(2);
    check("midreset_x", int'(xpos), 512);
    check("midreset_y", int'(ypos), 384);
    check("midreset_btn", int'({middle_mouse, right_mouse, left_mouse}), 0);
    rst = 1'b1;
    idle(3);
    send_pkt(8'h09, 8'h00, 8'h00, 512, 384, 1);
    idle(6);

    check("pending_expectations", exp_q.size(), 0);
    check("packet_count", pv_seen, 17);
    check("serr_total", serr_seen, 2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/mouse_tracker.md
MOUSE_TRACKER -- requirements
Module: mouse_tracker

Interface
REQ-001 Parameter H_MAX, default 1023: largest legal xpos value.
REQ-002 Parameter V_MAX, default 767: largest legal ypos value.
REQ-003 Parameter X_INIT, default 512: xpos value after reset.
REQ-004 Parameter Y_INIT, default 384: ypos value after reset.
REQ-005 Parameter PKT_TIMEOUT, default 100_000: idle cycles allowed between bytes of one packet.
REQ-006 clk  input  1  single system clock; all logic on its rising edge.
REQ-007 rst  input  1  reset, synchronous and active-low (asserted when 0).
REQ-008 rx_data  input  8  PS/2 mouse byte from the byte receiver.
REQ-009 rx_valid  input  1  one-cycle strobe qualifying rx_data.
REQ-010 xpos  output  12  cursor X, 0..H_MAX.
REQ-011 ypos  output  12  cursor Y, 0..V_MAX; 0 is the top of the screen.
REQ-012 left_mouse / right_mouse / middle_mouse  output  1 each  button levels from the last accepted packet.
REQ-013 packet_valid  output  1  one-cycle pulse when outputs update.
REQ-014 sync_err  output  1  one-cycle pulse on a discarded byte or packet.

Function
REQ-015 FSM states SHALL be WAIT_B0, WAIT_B1, WAIT_B2 and UPDATE; the reset state SHALL be WAIT_B0.
REQ-016 WAIT_B0: rx_valid with rx_data[3]=1 SHALL latch byte0 and go to WAIT_B1.
REQ-017 WAIT_B0: rx_valid with rx_data[3]=0 SHALL discard the byte, pulse sync_err and remain in WAIT_B0.
REQ-018 WAIT_B1 and WAIT_B2: rx_valid SHALL latch byte1 or byte2 respectively and advance; WAIT_B2 advances to UPDATE.
REQ-019 UPDATE SHALL last exactly one cycle, apply the packet, assert packet_valid and return to WAIT_B0.
REQ-020 An rx_valid arriving during UPDATE SHALL be processed as a WAIT_B0 byte (no byte dropped).
REQ-021 Byte0 decode: bit0=L, bit1=R, bit2=M, bit4=XS, bit5=YS, bit6=XO, bit7=YO.
REQ-022 dx SHALL be the 9-bit two's-complement value {XS,byte1}; dy SHALL be {YS,byte2}.
REQ-023 Intermediate sums SHALL use 14-bit signed arithmetic so that no wrap occurs.
REQ-024 x_new = clamp(xpos + dx, 0, H_MAX).
REQ-025 y_new = clamp(ypos - dy, 0, V_MAX), because PS/2 positive Y means up.
REQ-026 If XO=1, xpos SHALL be left unchanged; if YO=1, ypos SHALL be left unchanged; buttons SHALL still update.
REQ-027 xpos, ypos and the buttons SHALL change only in the UPDATE cycle, and all of them in that same cycle.
REQ-028 The outputs SHALL show the new values on the first rising edge after UPDATE, with packet_valid high for that one cycle.
REQ-029 Latency SHALL be 2 clk edges from the byte2 strobe to updated outputs.
REQ-030 A 20-bit idle counter SHALL run in WAIT_B1 and WAIT_B2 and clear on every rx_valid.
REQ-031 When the idle counter reaches PKT_TIMEOUT, the FSM SHALL return to WAIT_B0, pulse sync_err and drop the partial packet.
REQ-032 An rx_valid in the timeout cycle SHALL be treated as a WAIT_B0 byte.
REQ-033 The idle counter SHALL be held at 0 in WAIT_B0 and UPDATE.

Reset
REQ-034 While rst=0 at a clock edge: state=WAIT_B0, xpos=X_INIT, ypos=Y_INIT, all buttons=0, packet_valid=0, sync_err=0, idle counter=0, latched bytes=0.
REQ-035 Reset asserted mid-packet SHALL drop the partial packet with no output update and no sync_err pulse.
REQ-036 After rst returns to 1, the first rx_valid SHALL be evaluated as byte0.

Verification
REQ-037 Scenario: after reset, send 0x09, 0x10, 0x05 -> xpos=528, ypos=379, left_mouse=1, packet_valid pulses once, 2 edges after the third strobe.
REQ-038 Scenario: xpos=1020, send 0x08, 0x20, 0x00 -> xpos=1023 (clamped); then 0x38, 0x80, 0x80 -> xpos=895, ypos=512.
REQ-039 Scenario: ypos=5, send 0x08, 0x00, 0x0A -> ypos=0; send 0x48, 0xFF, 0x00 (XO=1) -> xpos unchanged, packet_valid=1.
REQ-040 Scenario: send 0x00 in WAIT_B0 -> sync_err pulse, no state change; then 0x0C, 0x00, 0x00 -> middle_mouse=1.
REQ-041 Scenario: send 0x09, then idle PKT_TIMEOUT cycles -> sync_err pulse, FSM in WAIT_B0; the next 0x0A, 0x01, 0x01 is applied as a fresh packet.
REQ-042 Scenario: rst=0 between byte1 and byte2 -> outputs return to 512/384 with buttons 0; 0x09, 0x00, 0x00 after release -> left_mouse=1.
